sensor_hub_aggregator: RTL and testbench



---
 rtl/sensor_hub_pkg.sv | 26 ++
 rtl/sensor_hub_aggregator_sync_fifo.sv | 61 ++++++
 rtl/sensor_hub_aggregator.sv | 241 ++++++++++++++++++++++++
 tb/tb_sensor_hub_aggregator.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_hub_pkg.sv
// sensor_hub_pkg
// Shared constants and types for the sensor hub aggregator:
//   HDR_BYTE     - first byte of every packet
//   MAX_CH       - upper bound on the number of sensor channels
//   frm_state_t  - framer FSM states
//   arb_mode_t   - arbitration mode encoding of the arb_mode input
package sensor_hub_pkg;

    localparam int         MAX_CH   = 8;
    localparam logic [7:0] HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ID,
        ST_TS,
        ST_DATA,
        ST_CSUM
    } frm_state_t;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

endpackage

// File: rtl/sensor_hub_aggregator_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with a combinational head (dout shows the oldest entry).
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle, so the FIFO stays full.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   push, pop    write and read requests (ignored when full / empty)
//   din          write data
//   dout         head entry, valid while empty=0
//   empty, full  occupancy flags
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sensor_hub_aggregator.sv
// sensor_hub_aggregator
// Timestamps single-cycle sensor strobes, buffers them per channel, arbitrates
// (fixed priority or round-robin) and frames each sample as
//   A5 | id | timestamp (MSB first) | data (MSB first) | xor checksum
// on a valid/ready byte stream.
// Ports:
//   clk, rst_n    clock / asynchronous active-low reset
//   enable        global freeze when low (no capture, timers/FSM/outputs held)
//   arb_mode      0 fixed priority (lowest index), 1 round-robin
//   ch_data       NUM_CH packed samples, channel i at [i*DATA_W +: DATA_W]
//   ch_valid      per-channel sample strobe (no backpressure)
//   out_byte, out_valid, out_ready   packet byte stream
//   overflow      sticky per-channel drop flag, ovf_clr clears (drop wins)
//   pkt_count     completed packets, wraps at 2^16
//   busy          framer not idle
//   pending       per-channel FIFO non-empty
module sensor_hub_aggregator
    import sensor_hub_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TS_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     arb_mode,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_valid,
    output logic [7:0]               out_byte,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH-1:0]        overflow,
    input  logic [NUM_CH-1:0]        ovf_clr,
    output logic [15:0]              pkt_count,
    output logic                     busy,
    output logic [NUM_CH-1:0]        pending
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ID_W   = $clog2(MAX_CH);
    localparam int ENT_W  = TS_W + DATA_W;
    localparam int TS_B   = TS_W / 8;
    localparam int DATA_B = DATA_W / 8;
    localparam logic [2:0] TS_LAST   = 3'(TS_B - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_B - 1);

    logic [TS_W-1:0]   ts;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] drop;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] full;
    logic [ENT_W-1:0]  fifo_dout [NUM_CH];
    logic [ENT_W-1:0]  head;

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant_id;
    logic              grant_valid;
    int                search_base;
    logic              take;

    frm_state_t        state;
    frm_state_t        state_nxt;
    logic [2:0]        byte_cnt;
    logic [2:0]        byte_cnt_nxt;
    logic              xfer;
    logic              pkt_done;

    logic [TS_W-1:0]   pkt_ts;
    logic [DATA_W-1:0] pkt_data;
    logic [ID_W-1:0]   pkt_ch;
    logic [7:0]        id_byte;
    logic [7:0]        ts_byte;
    logic [7:0]        data_byte;
    logic [7:0]        csum;

    // ---------------- capture ----------------
    // A full FIFO may still take a sample when its head leaves this cycle.
    assign push = {NUM_CH{enable}} & ch_valid & (~full | pop);
    assign drop = {NUM_CH{enable}} & ch_valid & full & ~pop;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        sync_fifo #(
            .WIDTH (ENT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   ({ts, ch_data[g*DATA_W +: DATA_W]}),
            .dout  (fifo_dout[g]),
            .empty (empty[g]),
            .full  (full[g])
        );
    end

    assign pending = ~empty;

    // ---------------- arbitration ----------------
    // Round-robin searches from rr_ptr upward, then wraps to the low channels.
    // Fixed priority is the same search starting from channel 0.
    always_comb begin
        search_base = (arb_mode_t'(arb_mode) == ARB_RR) ? int'(rr_ptr) : 0;
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!grant_valid && !empty[c] && (c >= search_base)) begin
                grant_valid = 1'b1;
                grant_id    = CH_W'(c);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!grant_valid && !empty[c]) begin
                grant_valid = 1'b1;
                grant_id    = CH_W'(c);
            end
        end
    end

    assign take = enable && (state == ST_IDLE) && grant_valid;

    always_comb begin
        pop  = '0;
        head = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_id == CH_W'(c)) begin
                pop[c] = take;
                head   = fifo_dout[c];
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts        <= '0;
            overflow  <= '0;
            rr_ptr    <= '0;
            pkt_ts    <= '0;
            pkt_data  <= '0;
            pkt_ch    <= '0;
            pkt_count <= '0;
        end else if (enable) begin
            ts       <= ts + 1'b1;
            overflow <= (overflow & ~ovf_clr) | drop;
            if (take) begin
                {pkt_ts, pkt_data} <= head;
                pkt_ch             <= ID_W'(grant_id);
                rr_ptr             <= (int'(grant_id) == NUM_CH - 1) ? '0 : grant_id + 1'b1;
            end
            if (pkt_done) pkt_count <= pkt_count + 1'b1;
        end
    end

    // ---------------- packet bytes ----------------
    assign id_byte = {{(8-ID_W){1'b0}}, pkt_ch};

    always_comb begin
        ts_byte   = 8'(pkt_ts   >> (8 * (TS_B   - 1 - int'(byte_cnt))));
        data_byte = 8'(pkt_data >> (8 * (DATA_B - 1 - int'(byte_cnt))));
        csum      = id_byte;
        for (int b = 0; b < TS_B; b++)   csum = csum ^ pkt_ts[8*b +: 8];
        for (int b = 0; b < DATA_B; b++) csum = csum ^ pkt_data[8*b +: 8];
    end

    // ---------------- framer FSM ----------------
    assign xfer = enable && out_ready && (state != ST_IDLE);
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
        end else if (enable) begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        out_valid    = 1'b1;
        out_byte     = 8'h00;
        pkt_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                out_valid = 1'b0;
                if (take) state_nxt = ST_HDR;
            end
            ST_HDR: begin
                out_byte = HDR_BYTE;
                if (xfer) state_nxt = ST_ID;
            end
            ST_ID: begin
                out_byte = id_byte;
                if (xfer) begin
                    state_nxt    = ST_TS;
                    byte_cnt_nxt = '0;
                end
            end
            ST_TS: begin
                out_byte = ts_byte;
                if (xfer) begin
                    if (byte_cnt == TS_LAST) begin
                        state_nxt    = ST_DATA;
                        byte_cnt_nxt = '0;
                    end else begin
                        byte_cnt_nxt = byte_cnt + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                out_byte = data_byte;
                if (xfer) begin
                    if (byte_cnt == DATA_LAST) begin
                        state_nxt    = ST_CSUM;
                        byte_cnt_nxt = '0;
                    end else begin
                        byte_cnt_nxt = byte_cnt + 1'b1;
                    end
                end
            end
            ST_CSUM: begin
                out_byte = csum;
                if (xfer) begin
                    state_nxt = ST_IDLE;
                    pkt_done  = 1'b1;
                end
            end
            default: begin
                out_valid = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sensor_hub_aggregator.sv
// Bench for sensor_hub_aggregator with default parameters (3 channels,
// 16-bit data and timestamp, 4-deep FIFOs). A transaction-level model
// (per-channel queues, a byte list for the packet in flight) is checked
// against the DUT every cycle; directed tests pin the model with literals.
module tb_sensor_hub_aggregator;

    localparam int NCH = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        arb_mode = 1'b0;
    logic [47:0] ch_data = '0;
    logic [2:0]  ch_valid = '0;
    logic [2:0]  ovf_clr = '0;
    logic        out_ready = 1'b0;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic [2:0]  overflow;
    logic [2:0]  pending;
    logic [15:0] pkt_count;
    logic        busy;

    always #5 clk = ~clk;

    sensor_hub_aggregator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .arb_mode  (arb_mode),
        .ch_data   (ch_data),
        .ch_valid  (ch_valid),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .pkt_count (pkt_count),
        .busy      (busy),
        .pending   (pending)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq [NCH][$];
    logic [7:0]  mpkt [$];
    int          midx = 0;
    bit          mbusy = 1'b0;
    int          m_ts = 0;
    int          m_rr = 0;
    int          m_cnt = 0;
    logic [2:0]  m_ovf = '0;

    always @(posedge clk or negedge rst_n) begin
        int          g;
        int          c;
        logic [31:0] e;
        logic [7:0]  cs;
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) mq[i].delete();
            mpkt.delete();
            midx  = 0;
            mbusy = 1'b0;
            m_ts  = 0;
            m_rr  = 0;
            m_cnt = 0;
            m_ovf = '0;
        end else if (enable) begin
            if (!mbusy) begin
                g = -1;
                for (int k = 0; k < NCH; k++) begin
                    c = arb_mode ? (m_rr + k) % NCH : k;
                    if (g < 0 && mq[c].size() > 0) g = c;
                end
                if (g >= 0) begin
                    e = mq[g].pop_front();
                    mpkt.delete();
                    mpkt.push_back(8'hA5);
                    mpkt.push_back(8'(g));
                    mpkt.push_back(e[31:24]);
                    mpkt.push_back(e[23:16]);
                    mpkt.push_back(e[15:8]);
                    mpkt.push_back(e[7:0]);
                    cs = 8'h00;
                    for (int k = 1; k < 6; k++) cs = cs ^ mpkt[k];
                    mpkt.push_back(cs);
                    midx  = 0;
                    mbusy = 1'b1;
                    m_rr  = (g + 1) % NCH;
                end
            end else if (out_ready) begin
                midx++;
                if (midx == mpkt.size()) begin
                    mbusy = 1'b0;
                    m_cnt = (m_cnt + 1) & 32'hFFFF;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (ch_valid[i] && mq[i].size() < 4)
                    mq[i].push_back({m_ts[15:0], ch_data[i*16 +: 16]});
                else if (ch_valid[i])
                    m_ovf[i] = 1'b1;
                else if (ovf_clr[i])
                    m_ovf[i] = 1'b0;
                if (ch_valid[i] && ovf_clr[i] && mq[i].size() <= 4 && !m_ovf[i])
                    m_ovf[i] = 1'b0;
            end
            m_ts = (m_ts + 1) & 32'hFFFF;
        end
    end

    // ---------------- per-cycle compare + receive log ----------------
    logic [7:0] rx [$];
    logic [7:0] prev_byte = 8'h00;
    bit         prev_stall = 1'b0;

    always @(negedge clk) begin
        logic [2:0] pe;
        for (int i = 0; i < NCH; i++) pe[i] = (mq[i].size() != 0);
        chk("out_valid", 32'(out_valid), 32'(mbusy));
        chk("busy", 32'(busy), 32'(mbusy));
        chk("out_byte", 32'(out_byte), mbusy ? 32'(mpkt[midx]) : 32'h0);
        chk("pkt_count", 32'(pkt_count), 32'(m_cnt[15:0]));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("pending", 32'(pending), 32'(pe));
        if (prev_stall && out_valid) chk("stall_hold", 32'(out_byte), 32'(prev_byte));
        prev_stall = rst_n && out_valid && !(out_ready && enable);
        prev_byte  = out_byte;
        if (rst_n && enable && out_valid && out_ready) rx.push_back(out_byte);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [2:0] m, input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2);
        ch_valid = m;
        ch_data  = {d2, d1, d0};
        step();
        ch_valid = '0;
    endtask

    task automatic wait_cnt(input int target, input int budget);
        int n;
        n = 0;
        while (32'(pkt_count) != target && n < budget) begin
            step();
            n++;
        end
        chk("wait_pkts", 32'(pkt_count), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp1 [7];
        logic [7:0] exp5 [7];
        int         n;
        int         pc;

        exp1 = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h12, 8'h34, 8'h37}; // 01^00^10^12^34 = 37
        exp5 = '{8'hA5, 8'h01, 8'h04, 8'h00, 8'h12, 8'h34, 8'h23}; // 01^04^00^12^34 = 23

        enable    = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_byte", 32'(out_byte), 32'h0);
        chk("rst_pkt_count", 32'(pkt_count), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single sample on ch1 captured at timestamp 0x0010
        n = 0;
        while (m_ts != 16 && n < 100) begin step(); n++; end
        rx.delete();
        strobe(3'b010, 16'h0000, 16'h1234, 16'h0000);
        wait_cnt(1, 40);
        chk("t1_len", 32'(rx.size()), 32'd7);
        for (int k = 0; k < 7; k++) chk("t1_byte", 32'(rx[k]), 32'(exp1[k]));

        // fixed priority: all three at once, then ch0+ch2
        rx.delete();
        strobe(3'b111, 16'h1111, 16'h2222, 16'h3333);
        wait_cnt(4, 60);
        chk("t2_len", 32'(rx.size()), 32'd21);
        chk("t2_id0", 32'(rx[1]), 32'd0);
        chk("t2_id1", 32'(rx[8]), 32'd1);
        chk("t2_id2", 32'(rx[15]), 32'd2);
        chk("t2_ch1_data", 32'({rx[11], rx[12]}), 32'h2222);
        rx.delete();
        strobe(3'b101, 16'h5555, 16'h0000, 16'h6666);
        wait_cnt(6, 40);
        chk("t2b_id0", 32'(rx[1]), 32'd0);
        chk("t2b_id1", 32'(rx[8]), 32'd2);

        // round-robin between ch0 and ch2
        arb_mode = 1'b1;
        rx.delete();
        for (int k = 0; k < 3; k++) strobe(3'b101, 16'h0A00 + 16'(k), 16'h0000, 16'h0C00 + 16'(k));
        wait_cnt(12, 80);
        chk("t3_id0", 32'(rx[1]), 32'd0);
        chk("t3_id1", 32'(rx[8]), 32'd2);
        chk("t3_id2", 32'(rx[15]), 32'd0);
        chk("t3_id3", 32'(rx[22]), 32'd2);
        arb_mode = 1'b0;

        // overflow with the stream stalled
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) strobe(3'b001, 16'h4000 + 16'(k), 16'h0000, 16'h0000);
        chk("t4_ovf_set", 32'(overflow[0]), 32'h1);
        chk("t4_pending", 32'(pending[0]), 32'h1);
        ovf_clr = 3'b001;
        step();
        ovf_clr = 3'b000;
        chk("t4_ovf_clr", 32'(overflow[0]), 32'h0);
        ovf_clr = 3'b001;
        strobe(3'b001, 16'h4006, 16'h0000, 16'h0000);
        ovf_clr = 3'b000;
        chk("t4_clr_vs_drop", 32'(overflow[0]), 32'h1);
        // keep ch0 full while it drains: pops and pushes coincide
        out_ready = 1'b1;
        for (int k = 0; k < 30; k++) strobe(3'b001, 16'h4100 + 16'(k), 16'h0000, 16'h0000);
        n = 0;
        while ((busy || pending != 3'b000) && n < 100) begin step(); n++; end
        chk("t4_drain_busy", 32'(busy), 32'h0);
        chk("t4_drain_pending", 32'(pending), 32'h0);
        ovf_clr = 3'b111;
        step();
        ovf_clr = 3'b000;
        chk("t4_ovf_final", 32'(overflow), 32'h0);

        // backpressure and enable pause, sample captured at timestamp 0x0400
        n = 0;
        while (m_ts != 32'h400 && n < 3000) begin step(); n++; end
        chk("t5_ts_reached", 32'(m_ts), 32'h400);
        rx.delete();
        pc = m_cnt;
        strobe(3'b010, 16'h0000, 16'h1234, 16'h0000);
        for (int k = 0; k < 30; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            enable    = !(k >= 8 && k < 12);
            step();
        end
        out_ready = 1'b1;
        enable    = 1'b1;
        wait_cnt(pc + 1, 40);
        chk("t5_len", 32'(rx.size()), 32'd7);
        for (int k = 0; k < 7; k++) chk("t5_byte", 32'(rx[k]), 32'(exp5[k]));

        // reset during DATA
        strobe(3'b100, 16'h0000, 16'h0000, 16'hBEEF);
        n = 0;
        while (!(mbusy && midx == 5) && n < 30) begin step(); n++; end
        chk("t6_in_data", 32'(midx), 32'd5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", 32'(out_valid), 32'h0);
        chk("t6_out_byte", 32'(out_byte), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_pkt_count", 32'(pkt_count), 32'h0);
        chk("t6_pending", 32'(pending), 32'h0);
        chk("t6_overflow", 32'(overflow), 32'h0);
        step();
        rst_n = 1'b1;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
